riscv_instr_aligner: RTL and testbench

//  Fetch-to-decode aligner. Sits between the instruction-fetch port and the decoder.
//  - Buffers aligned 32-bit fetch words as 16-bit halfwords.
//  - Re-assembles 32-bit instructions that straddle word boundaries.
//  - Optionally passes RV32C 16-bit instructions, tagged, for later expansion.
//  - Delivers one instruction per cycle, with its PC and a pre-extracted opcode[6:2], over valid/ready.

---
 rtl/riscv_instr_aligner.sv | 150 +++++++++++++++
 tb/tb_riscv_instr_aligner.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_instr_aligner.sv
`default_nettype none
// ============================================================================
// Module   : riscv_instr_aligner
// Purpose  : Fetch-to-decode aligner. Splits 32-bit fetch words into a
//            halfword ring buffer, re-assembles 32-bit instructions that
//            straddle word boundaries, optionally passes 16-bit RV32C
//            encodings, and hands one instruction per cycle to decode with
//            its PC, opcode[6:2] and error/illegal tags over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_instr_aligner #(
  parameter int              C_EXT     = 1,
  parameter int              BUF_DEPTH = 4,
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [PC_W-1:0] flush_pc_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [31:0]     fetch_data_i,
  input  logic            fetch_err_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [PC_W-1:0] instr_pc_o,
  output logic            instr_is_c_o,
  output logic [4:0]      instr_opcode_o,
  output logic            instr_err_o,
  output logic            instr_illegal_o
);

  localparam int              PTR_W      = $clog2(BUF_DEPTH);
  // Wide enough to hold count + 2 without overflow in the push-space check.
  localparam int              CNT_W      = $clog2(BUF_DEPTH + 3);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(BUF_DEPTH);
  localparam logic            CEXT_B     = (C_EXT != 0);
  // Redirect targets are halfword aligned with C, word aligned without it.
  localparam logic [PC_W-1:0] FLUSH_MASK = CEXT_B ? ~PC_W'(1) : ~PC_W'(3);

  logic [15:0]          half_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] err_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [PC_W-1:0]      pc_q;
  logic                 drop_q;

  logic [PTR_W-1:0] rd_ptr1;
  logic [PTR_W-1:0] rd_ptr2;
  logic [PTR_W-1:0] wr_ptr1;
  logic [PTR_W-1:0] wr_ptr2;
  logic [15:0]      head_lo;
  logic [15:0]      head_hi;
  logic             head_is_c;
  logic [CNT_W-1:0] need;
  logic [CNT_W-1:0] push_need;
  logic [CNT_W-1:0] push_cnt;
  logic [CNT_W-1:0] pop_cnt;
  logic [31:0]      raw_instr;
  logic             push;
  logic             pop;

  // Ring pointer increment that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Head decode, handshake and push/pop qualification.
  always_comb begin
    rd_ptr1   = ptr_inc(rd_ptr_q);
    rd_ptr2   = ptr_inc(rd_ptr1);
    wr_ptr1   = ptr_inc(wr_ptr_q);
    wr_ptr2   = ptr_inc(wr_ptr1);
    head_lo   = half_q[rd_ptr_q];
    head_hi   = half_q[rd_ptr1];
    head_is_c = CEXT_B && (head_lo[1:0] != 2'b11);
    need      = head_is_c ? CNT_W'(1) : CNT_W'(2);
    raw_instr = head_is_c ? {16'h0000, head_lo} : {head_hi, head_lo};

    instr_valid_o = (count_q >= need);
    // Everything except the PC reads as zero while no instruction is ready.
    instr_o         = instr_valid_o ? raw_instr : 32'h0;
    instr_opcode_o  = instr_o[6:2];
    instr_is_c_o    = instr_valid_o && head_is_c;
    instr_err_o     = instr_valid_o && (err_q[rd_ptr_q] || (!head_is_c && err_q[rd_ptr1]));
    instr_illegal_o = instr_valid_o && !CEXT_B && (head_lo[1:0] != 2'b11);
    instr_pc_o      = pc_q;

    push_need     = drop_q ? CNT_W'(1) : CNT_W'(2);
    // Space check uses the pre-pop count: no push into a full buffer while popping.
    fetch_ready_o = !flush_i && ((count_q + push_need) <= DEPTH_C);
    push          = fetch_valid_i && fetch_ready_o;
    pop           = instr_valid_o && instr_ready_i && !flush_i;
    push_cnt      = push ? push_need : '0;
    pop_cnt       = pop ? need : '0;
  end

  // Halfword storage: write low then high half, or only the high half when dropping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        half_q[i] <= 16'h0000;
      end
      err_q <= '0;
    end else if (push) begin
      if (drop_q) begin
        half_q[wr_ptr_q] <= fetch_data_i[31:16];
        err_q[wr_ptr_q]  <= fetch_err_i;
      end else begin
        half_q[wr_ptr_q] <= fetch_data_i[15:0];
        err_q[wr_ptr_q]  <= fetch_err_i;
        half_q[wr_ptr1]  <= fetch_data_i[31:16];
        err_q[wr_ptr1]   <= fetch_err_i;
      end
    end
  end

  // Pointers, occupancy, PC and drop flag; flush overrides push and pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= RESET_PC;
      drop_q   <= CEXT_B && RESET_PC[1];
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= flush_pc_i & FLUSH_MASK;
      drop_q   <= CEXT_B && flush_pc_i[1];
    end else begin
      if (push) begin
        wr_ptr_q <= drop_q ? wr_ptr1 : wr_ptr2;
        drop_q   <= 1'b0;
      end
      if (pop) begin
        rd_ptr_q <= head_is_c ? rd_ptr1 : rd_ptr2;
        pc_q     <= pc_q + (head_is_c ? PC_W'(2) : PC_W'(4));
      end
      count_q <= count_q + push_cnt - pop_cnt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_instr_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_instr_aligner
// Purpose  : Scoreboard bench for riscv_instr_aligner (C and non-C builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_instr_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_data = '0;
  logic        fetch_err = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_is_c;
  logic [4:0]  instr_opcode;
  logic        instr_err;
  logic        instr_illegal;

  // Second instance built without C support.
  logic        fetch_valid2 = 1'b0;
  logic        fetch_ready2;
  logic [31:0] fetch_data2 = '0;
  logic        instr_valid2;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;
  logic        instr_is_c2;
  logic [4:0]  instr_opcode2;
  logic        instr_err2;
  logic        instr_illegal2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        is_c;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  riscv_instr_aligner #(.C_EXT(1), .BUF_DEPTH(4), .PC_W(32), .RESET_PC(32'h80)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_pc_i(flush_pc),
    .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready),
    .fetch_data_i(fetch_data), .fetch_err_i(fetch_err),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .instr_pc_o(instr_pc), .instr_is_c_o(instr_is_c),
    .instr_opcode_o(instr_opcode), .instr_err_o(instr_err),
    .instr_illegal_o(instr_illegal)
  );

  riscv_instr_aligner #(.C_EXT(0), .BUF_DEPTH(4), .PC_W(32), .RESET_PC(32'h0)) dut_nc (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .flush_pc_i(32'h0),
    .fetch_valid_i(fetch_valid2), .fetch_ready_o(fetch_ready2),
    .fetch_data_i(fetch_data2), .fetch_err_i(1'b0),
    .instr_valid_o(instr_valid2), .instr_ready_i(1'b0),
    .instr_o(instr2), .instr_pc_o(instr_pc2), .instr_is_c_o(instr_is_c2),
    .instr_opcode_o(instr_opcode2), .instr_err_o(instr_err2),
    .instr_illegal_o(instr_illegal2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_instr(input logic [31:0] i, input logic [31:0] pc,
                              input logic c, input logic e);
    exp_t x;
    x.instr = i; x.pc = pc; x.is_c = c; x.err = e;
    exp_q.push_back(x);
  endtask

  // Offer one fetch word until accepted; entered and left just after a posedge.
  task automatic send_word(input logic [31:0] d, input logic e);
    logic done = 1'b0;
    int   n = 0;
    fetch_valid = 1'b1;
    fetch_data  = d;
    fetch_err   = e;
    while (!done && n < 200) begin
      @(negedge clk);
      done = fetch_ready;
      @(posedge clk);
      #1;
      n++;
    end
    fetch_valid = 1'b0;
    fetch_err   = 1'b0;
    if (!done) check_eq("fetch_accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check_eq("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Redirect, also offering a word that must be refused in the flush cycle.
  task automatic do_flush(input logic [31:0] pc);
    flush       = 1'b1;
    flush_pc    = pc;
    fetch_valid = 1'b1;
    fetch_data  = 32'hdeadbeef;
    @(negedge clk);
    check_eq("flush_refuse", 64'(fetch_ready), 64'd0);
    @(posedge clk);
    #1;
    flush       = 1'b0;
    fetch_valid = 1'b0;
  endtask

  // Scoreboard: compare every consumed instruction against the queue head.
  always @(negedge clk) begin
    if (!rst && !flush && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_instr", 64'(exp_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("instr", 64'(instr), 64'(e.instr));
        check_eq("pc", 64'(instr_pc), 64'(e.pc));
        check_eq("is_c", 64'(instr_is_c), 64'(e.is_c));
        check_eq("err", 64'(instr_err), 64'(e.err));
        check_eq("opcode", 64'(instr_opcode), 64'(e.instr[6:2]));
        check_eq("illegal", 64'(instr_illegal), 64'd0);
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(instr_valid), 64'd0);
    check_eq("rst_fready", 64'(fetch_ready), 64'd1);
    check_eq("rst_pc", 64'(instr_pc), 64'h80);
    check_eq("rst_instr", 64'(instr), 64'd0);
    check_eq("rst_is_c", 64'(instr_is_c), 64'd0);
    check_eq("rst_err", 64'(instr_err), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single aligned 32-bit instruction
    expect_instr(32'h00500093, 32'h80, 1'b0, 1'b0);
    send_word(32'h00500093, 1'b0);
    wait_drain();

    // Two compressed then one 32-bit
    do_flush(32'h80);
    expect_instr(32'h00004501, 32'h80, 1'b1, 1'b0);
    expect_instr(32'h00004505, 32'h82, 1'b1, 1'b0);
    expect_instr(32'h00000013, 32'h84, 1'b0, 1'b0);
    send_word(32'h45054501, 1'b0);
    send_word(32'h00000013, 1'b0);
    wait_drain();

    // Straddle, clean then with error on the upper-half word
    for (int pass = 0; pass < 2; pass++) begin
      do_flush(32'h80);
      expect_instr(32'h00000001, 32'h80, 1'b1, 1'b0);
      expect_instr(32'h00500093, 32'h82, 1'b0, 1'(pass));
      expect_instr(32'h00000000, 32'h86, 1'b1, 1'(pass));
      send_word(32'h00930001, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("straddle_wait", 64'(instr_valid), 64'd0);
      @(posedge clk);
      #1;
      send_word(32'h00000050, 1'(pass));
      wait_drain();
    end

    // Flush to a halfword-offset target drops the low half
    do_flush(32'h102);
    expect_instr(32'h00000001, 32'h102, 1'b1, 1'b0);
    send_word(32'h00014501, 1'b0);
    wait_drain();

    // Backpressure with continuous fetch
    do_flush(32'h200);
    instr_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          logic [15:0] h0;
          logic [15:0] h1;
          h0 = 16'h4001 + 16'(k * 8);
          h1 = h0 + 16'h4;
          expect_instr({16'h0, h0}, 32'h200 + 32'(k * 4), 1'b1, 1'b0);
          expect_instr({16'h0, h1}, 32'h202 + 32'(k * 4), 1'b1, 1'b0);
          send_word({h1, h0}, 1'b0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check_eq("bp_hold_instr", 64'(instr), 64'h4001);
          check_eq("bp_fready", 64'(fetch_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
      end
    join
    wait_drain();

    // Non-C build flags a 16-bit encoding as illegal
    fetch_valid2 = 1'b1;
    fetch_data2  = 32'h00004501;
    @(posedge clk);
    #1;
    fetch_valid2 = 1'b0;
    @(negedge clk);
    check_eq("nc_valid", 64'(instr_valid2), 64'd1);
    check_eq("nc_instr", 64'(instr2), 64'h00004501);
    check_eq("nc_illegal", 64'(instr_illegal2), 64'd1);
    check_eq("nc_is_c", 64'(instr_is_c2), 64'd0);
    check_eq("nc_pc", 64'(instr_pc2), 64'd0);

    // Reset mid-stream discards buffered data
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    send_word(32'h00000013, 1'b0);
    @(negedge clk);
    check_eq("pre_rst_valid", 64'(instr_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 64'(instr_valid), 64'd0);
    check_eq("mid_rst_pc", 64'(instr_pc), 64'h80);
    check_eq("mid_rst_fready", 64'(fetch_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
